axi_mem_responder: RTL and testbench

//   AXI4 slave (responder) that answers the SoC's 32-bit AXI master bursts (frmbuf/ram style) from on-chip memory.

---
 rtl/axi_mem_responder.sv | 155 +++++++++++++++
 tb/tb_axi_mem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 slave that serves one 32-bit write or read burst at a time from on-chip memory.
// Optional per-beat decode-error checking is enabled by defining AXI_MEM_RESP_DECERR_EN.
module axi_mem_responder #(
  parameter int    ADDR_W      = 32,
  parameter int    DEPTH_WORDS = 4096,
  parameter int    LEN_W       = 4,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [LEN_W-1:0]  s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [1:0]        s_axi_bresp,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [LEN_W-1:0]  s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       s_axi_rdata,
  output logic              s_axi_rlast,
  output logic [1:0]        s_axi_rresp
);
  // Every channel: a transfer happens on a rising edge where valid and ready are both high;
  // valid, once raised, is held with stable payload until that edge.
  localparam int WA = ADDR_W - 2;
  localparam int IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;
  typedef enum logic {PRIO_WRITE, PRIO_READ} prio_t;

  state_t           state, state_nxt;
  prio_t            prio;
  logic [31:0]      mem [DEPTH_WORDS];
  logic [WA-1:0]    addr, addr_nxt, rd_addr;
  logic [LEN_W-1:0] len, beat;
  logic [1:0]       burst;
  logic             wr_err, wr_dec, wr_oob, rd_oob;
  logic             aw_win, ar_win, aw_hs, ar_hs, w_hs, r_hs, rd_load;

  assign aw_win = s_axi_awvalid && (!s_axi_arvalid || prio == PRIO_WRITE);
  assign ar_win = s_axi_arvalid && (!s_axi_awvalid || prio == PRIO_READ);

  assign s_axi_awready = (state == IDLE) && aw_win;
  assign s_axi_arready = (state == IDLE) && ar_win;
  assign s_axi_wready  = (state == WR_DATA);
  assign s_axi_bvalid  = (state == WR_RESP);
  assign s_axi_rvalid  = (state == RD_DATA);
  assign s_axi_bresp   = wr_dec ? 2'b11 : (wr_err ? 2'b10 : 2'b00);

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign r_hs    = s_axi_rvalid && s_axi_rready;
  assign rd_load = ar_hs || (r_hs && !s_axi_rlast);

  // FIXED holds the word address; INCR and WRAP both step by one word.
  assign addr_nxt = (burst == 2'b00) ? addr : addr + WA'(1);
  assign rd_addr  = ar_hs ? s_axi_araddr[ADDR_W-1:2] : addr_nxt;

`ifdef AXI_MEM_RESP_DECERR_EN
  localparam logic [WA-1:0] DEPTH_LIM = WA'(DEPTH_WORDS);
  assign wr_oob = (addr >= DEPTH_LIM);
  assign rd_oob = (rd_addr >= DEPTH_LIM);
`else
  assign wr_oob = 1'b0;
  assign rd_oob = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, s_axi_awsize, s_axi_arsize, s_axi_awaddr[1:0],
                       s_axi_araddr[1:0], rd_addr};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (aw_win) state_nxt = WR_DATA;
               else if (ar_win) state_nxt = RD_DATA;
      WR_DATA: if (w_hs && beat == len) state_nxt = WR_RESP;
      WR_RESP: if (s_axi_bready) state_nxt = IDLE;
      RD_DATA: if (r_hs && s_axi_rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory has no reset so committed data survives a mid-burst reset.
  always_ff @(posedge clk) begin
    if (w_hs && !wr_oob) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b]) mem[addr[IW-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prio        <= PRIO_WRITE;
      addr        <= '0;
      len         <= '0;
      burst       <= '0;
      beat        <= '0;
      wr_err      <= 1'b0;
      wr_dec      <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_rlast <= 1'b0;
      s_axi_rresp <= 2'b00;
    end else begin
      state <= state_nxt;
      if (aw_hs) begin
        addr   <= s_axi_awaddr[ADDR_W-1:2];
        len    <= s_axi_awlen;
        burst  <= s_axi_awburst;
        beat   <= '0;
        wr_err <= 1'b0;
        wr_dec <= 1'b0;
        prio   <= PRIO_READ;
      end else if (ar_hs) begin
        addr  <= rd_addr;
        len   <= s_axi_arlen;
        burst <= s_axi_arburst;
        beat  <= '0;
        prio  <= PRIO_WRITE;
      end else if (w_hs || (r_hs && !s_axi_rlast)) begin
        addr <= addr_nxt;
        beat <= beat + LEN_W'(1);
      end
      if (w_hs) begin
        if (s_axi_wlast != (beat == len)) wr_err <= 1'b1;
        if (wr_oob) wr_dec <= 1'b1;
      end
      // Read outputs only move on a transfer, so they stay stable while rready is low.
      if (rd_load) begin
        s_axi_rdata <= rd_oob ? 32'h0 : mem[rd_addr[IW-1:0]];
        s_axi_rresp <= rd_oob ? 2'b11 : 2'b00;
        s_axi_rlast <= ar_hs ? (s_axi_arlen == '0) : (beat + LEN_W'(1) == len);
      end else if (r_hs) begin
        s_axi_rlast <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized bench for axi_mem_responder with a word-array memory model and expected-beat queue.
module tb_axi_mem_responder;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 64;
  localparam int LEN_W  = 4;
`ifdef AXI_MEM_RESP_DECERR_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_axi_awvalid, s_axi_awready;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic [LEN_W-1:0]  s_axi_awlen;
  logic [2:0]        s_axi_awsize;
  logic [1:0]        s_axi_awburst;
  logic              s_axi_wvalid, s_axi_wready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wlast;
  logic              s_axi_bvalid, s_axi_bready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_arvalid, s_axi_arready;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [LEN_W-1:0]  s_axi_arlen;
  logic [2:0]        s_axi_arsize;
  logic [1:0]        s_axi_arburst;
  logic              s_axi_rvalid, s_axi_rready;
  logic [31:0]       s_axi_rdata;
  logic              s_axi_rlast;
  logic [1:0]        s_axi_rresp;

  axi_mem_responder #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rlast(s_axi_rlast), .s_axi_rresp(s_axi_rresp)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int          total = 0;
  int          bad = 0;
  logic [31:0] mem_m [DEPTH];
  logic [34:0] exp_q [$];
  logic [31:0] wdata_a [16];
  logic [3:0]  wstrb_a [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_oob(input logic [29:0] a);
    return DEC_EN && (a >= 30'(DEPTH));
  endfunction

  function automatic int widx(input logic [29:0] a);
    return int'(a % 30'(DEPTH));
  endfunction

  // driver: write burst; model update first, then AW, W beats, B
  task automatic write_burst(input logic [29:0] wa, input int len, input logic [1:0] bst,
                             input int last_at, input bit stall);
    logic [29:0] a;
    logic [1:0]  exp_b;
    bit          err, dec, got, bv_pre;
    int          n;
    a = wa; err = 1'b0; dec = 1'b0; bv_pre = 1'b0; got = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (((last_at < 0) ? (i == len) : (i == last_at)) != (i == len)) err = 1'b1;
      if (is_oob(a)) dec = 1'b1;
      else for (int b = 0; b < 4; b++)
        if (wstrb_a[i][b]) mem_m[widx(a)][8*b +: 8] = wdata_a[i][8*b +: 8];
      if (bst != 2'b00) a = a + 30'd1;
    end
    exp_b = dec ? 2'b11 : (err ? 2'b10 : 2'b00);
    @(posedge clk); #1;
    s_axi_awaddr = {wa, 2'b00}; s_axi_awlen = len[LEN_W-1:0]; s_axi_awburst = bst;
    s_axi_awsize = 3'd2; s_axi_awvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); got = s_axi_awready;
      @(posedge clk); #1; n++;
    end while (!got && n < 40);
    s_axi_awvalid = 1'b0;
    check("aw_hs", 64'(got), 64'd1);
    for (int i = 0; i <= len; i++) begin
      if (stall) repeat ($urandom_range(0, 2)) begin s_axi_wvalid = 1'b0; @(posedge clk); #1; end
      s_axi_wvalid = 1'b1; s_axi_wdata = wdata_a[i]; s_axi_wstrb = wstrb_a[i];
      s_axi_wlast = (last_at < 0) ? (i == len) : (i == last_at);
      n = 0;
      do begin
        @(negedge clk); got = s_axi_wready; bv_pre = s_axi_bvalid;
        @(posedge clk); #1; n++;
      end while (!got && n < 40);
      if (!got) break;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check("w_hs", 64'(got), 64'd1);
    check("b_pre", 64'(bv_pre), 64'd0);
    @(negedge clk);
    check("b_lat", 64'(s_axi_bvalid), 64'd1);
    check("bresp", 64'(s_axi_bresp), 64'(exp_b));
    repeat ($urandom_range(0, 2)) @(negedge clk);
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    @(negedge clk);
    check("b_drop", 64'(s_axi_bvalid), 64'd0);
  endtask

  // driver: AR; expected beats {rresp, rlast, rdata} go to the scoreboard queue
  task automatic ar_phase(input logic [29:0] ra, input int len, input logic [1:0] bst);
    logic [29:0] a;
    bit          got, rv_pre;
    int          n;
    a = ra; got = 1'b0; rv_pre = 1'b0;
    for (int i = 0; i <= len; i++) begin
      exp_q.push_back({is_oob(a) ? 2'b11 : 2'b00, i == len, is_oob(a) ? 32'h0 : mem_m[widx(a)]});
      if (bst != 2'b00) a = a + 30'd1;
    end
    @(posedge clk); #1;
    s_axi_araddr = {ra, 2'b00}; s_axi_arlen = len[LEN_W-1:0]; s_axi_arburst = bst;
    s_axi_arsize = 3'd2; s_axi_arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); got = s_axi_arready; rv_pre = s_axi_rvalid;
      @(posedge clk); #1; n++;
    end while (!got && n < 40);
    s_axi_arvalid = 1'b0;
    check("ar_hs", 64'(got), 64'd1);
    check("r_pre", 64'(rv_pre), 64'd0);
    @(negedge clk);
    check("r_lat", 64'(s_axi_rvalid), 64'd1);
  endtask

  // scoreboard: mode 0 always ready, 1 random, 2 toggling
  task automatic r_phase(input int mode);
    int cyc;
    bit rr;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      rr = (mode == 0) ? 1'b1 : ((mode == 2) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1)));
      s_axi_rready = rr;
      check(rr ? "r_beat" : "r_hold", 64'({s_axi_rvalid, s_axi_rresp, s_axi_rlast, s_axi_rdata}),
            64'({1'b1, exp_q[0]}));
      if (rr) void'(exp_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    s_axi_rready = 1'b0;
    check("r_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check("r_end", 64'(s_axi_rvalid), 64'd0);
  endtask

  task automatic read_burst(input logic [29:0] ra, input int len, input logic [1:0] bst,
                            input int mode);
    ar_phase(ra, len, bst);
    r_phase(mode);
  endtask

  initial begin
    int          len, last_at;
    logic [29:0] ra;
    logic [1:0]  bst;
    s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd2;
    s_axi_awburst = 2'b01; s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wlast = 1'b0; s_axi_bready = 1'b0; s_axi_arvalid = 1'b0; s_axi_araddr = '0;
    s_axi_arlen = '0; s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_rready = 1'b0;
    #12;
    check("rst_ready", 64'({s_axi_awready, s_axi_arready, s_axi_wready}), 64'd0);
    check("rst_valid", 64'({s_axi_bvalid, s_axi_rvalid}), 64'd0);
    check("rst_rdata", 64'({s_axi_rlast, s_axi_rdata}), 64'd0);
    check("rst_resp", 64'({s_axi_bresp, s_axi_rresp}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // simultaneous AW/AR twice: write first, then read
    @(posedge clk); #1;
    s_axi_awaddr = {30'd33, 2'b00}; s_axi_araddr = {30'd33, 2'b00};
    s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
    #2 check("arb1", 64'({s_axi_awready, s_axi_arready}), 64'd2);
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    wdata_a[0] = 32'hC0FFEE01; wstrb_a[0] = 4'hF;
    write_burst(30'd33, 0, 2'b01, -1, 1'b0);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
    #2 check("arb2", 64'({s_axi_awready, s_axi_arready}), 64'd1);
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    read_burst(30'd33, 0, 2'b01, 0);

    // known memory image
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) begin wdata_a[i] = $urandom; wstrb_a[i] = 4'hF; end
      write_burst(30'(16 * k), 15, 2'b01, -1, 1'b0);
    end

    // basic INCR burst at byte 0x10
    for (int i = 0; i < 4; i++) begin wdata_a[i] = 32'hA0 + i; wstrb_a[i] = 4'hF; end
    write_burst(30'd4, 3, 2'b01, -1, 1'b0);
    read_burst(30'd4, 3, 2'b01, 0);

    // byte strobes at byte 0x40
    wdata_a[0] = 32'hFFFFFFFF; wstrb_a[0] = 4'hF;
    write_burst(30'd16, 0, 2'b01, -1, 1'b0);
    wdata_a[0] = 32'h12345678; wstrb_a[0] = 4'b0101;
    write_burst(30'd16, 0, 2'b01, -1, 1'b0);
    read_burst(30'd16, 0, 2'b01, 0);
    check("strobe_model", 64'(mem_m[16]), 64'hFF34FF78);

    // 16-beat read with rready toggling, and a read crossing the top of memory
    read_burst(30'd8, 15, 2'b01, 2);
    read_burst(30'(DEPTH - 2), 3, 2'b01, 1);

    // early wlast: still three beats, SLVERR
    for (int i = 0; i < 3; i++) begin wdata_a[i] = $urandom; wstrb_a[i] = 4'hF; end
    write_burst(30'd40, 2, 2'b01, 1, 1'b0);
    read_burst(30'd40, 2, 2'b01, 0);

    for (int t = 0; t < 40; t++) begin
      ra  = 30'($urandom_range(0, DEPTH + 3));
      len = int'($urandom_range(0, 15));
      bst = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin wdata_a[i] = $urandom; wstrb_a[i] = 4'($urandom); end
        last_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : -1;
        write_burst(ra, len, bst, last_at, 1'b1);
      end else begin
        read_burst(ra, len, bst, int'($urandom_range(0, 2)));
      end
    end

    // one word past the top
    read_burst(30'(DEPTH), 0, 2'b01, 0);

    // reset in the middle of a read burst
    ar_phase(30'd20, 15, 2'b01);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_mid", 64'({s_axi_rvalid, s_axi_bvalid, s_axi_wready, s_axi_rlast, s_axi_rdata}), 64'd0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    read_burst(30'd20, 3, 2'b01, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
